instr_fetch: RTL and testbench

//  IF stage of the RISC-V core. Owns the PC and drives the instruction-memory

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, drives the imem request/ready handshake and the IF/ID register.
// A one-entry skid absorbs a word returned while decode stalls; redirects flush fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  opcode
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold, StDrop} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_drop_addr, w_drop_addr_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic        r_if_id_valid, w_if_id_valid_nxt;
  logic [31:0] r_if_id_pc, w_if_id_pc_nxt;
  logic [31:0] r_if_id_instr, w_if_id_instr_nxt;

  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_accept;
  logic        w_to_skid;
  logic        w_load_fetch;
  logic        w_release;
  logic        w_bubble;

  assign w_target = branch_target & ~32'h3;
  assign w_pc_inc = r_pc + 32'd4;

  // A returned word is taken only in FETCH and only when no redirect overrides it.
  assign w_accept     = (r_state == StFetch) && imem_ready && !branch_taken;
  assign w_to_skid    = w_accept && stall && r_if_id_valid;
  assign w_load_fetch = w_accept && !w_to_skid;
  assign w_release    = (r_state == StHold) && r_skid_valid && !branch_taken && !stall;
  assign w_bubble     = (r_state == StFetch) && !imem_ready && !stall && !branch_taken;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StBoot: w_state_nxt = StFetch;
      StFetch: begin
        if (branch_taken) begin
          w_state_nxt = imem_ready ? StFetch : StDrop;
        end else if (w_to_skid) begin
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (branch_taken || !stall) begin
          w_state_nxt = StFetch;
        end
      end
      StDrop: begin
        if (imem_ready) begin
          w_state_nxt = StFetch;
        end
      end
      default: w_state_nxt = StBoot;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (r_state == StFetch) || (r_state == StDrop);
    imem_addr = (r_state == StDrop) ? r_drop_addr : r_pc;
  end

  // Datapath next-state: PC, drop address, skid and IF/ID
  always_comb begin
    w_pc_nxt          = r_pc;
    w_drop_addr_nxt   = r_drop_addr;
    w_skid_valid_nxt  = r_skid_valid;
    w_skid_pc_nxt     = r_skid_pc;
    w_skid_instr_nxt  = r_skid_instr;
    w_if_id_valid_nxt = r_if_id_valid;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_instr_nxt = r_if_id_instr;

    if (branch_taken) begin
      w_pc_nxt          = w_target;
      w_skid_valid_nxt  = 1'b0;
      w_if_id_valid_nxt = 1'b0;
      w_if_id_instr_nxt = NOP_INSTR;
      // The outstanding request keeps its address until the memory answers it.
      if ((r_state == StFetch) && !imem_ready) begin
        w_drop_addr_nxt = r_pc;
      end
    end else begin
      if (w_accept) begin
        w_pc_nxt = w_pc_inc;
      end
      if (w_load_fetch) begin
        w_if_id_valid_nxt = 1'b1;
        w_if_id_pc_nxt    = r_pc;
        w_if_id_instr_nxt = imem_rdata;
      end
      if (w_to_skid) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_pc_nxt    = r_pc;
        w_skid_instr_nxt = imem_rdata;
      end
      if (w_release) begin
        w_skid_valid_nxt  = 1'b0;
        w_if_id_valid_nxt = 1'b1;
        w_if_id_pc_nxt    = r_skid_pc;
        w_if_id_instr_nxt = r_skid_instr;
      end
      if (w_bubble) begin
        w_if_id_valid_nxt = 1'b0;
        w_if_id_instr_nxt = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_drop_addr   <= RESET_PC;
      r_skid_valid  <= 1'b0;
      r_skid_pc     <= 32'h0;
      r_skid_instr  <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= NOP_INSTR;
    end else begin
      r_pc          <= w_pc_nxt;
      r_drop_addr   <= w_drop_addr_nxt;
      r_skid_valid  <= w_skid_valid_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_skid_instr  <= w_skid_instr_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
    end
  end

  assign if_id_valid = r_if_id_valid;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign opcode      = r_if_id_instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random handshake/stall/redirect traffic,
// all compared against a behavioural fetch model.
module tb_instr_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  opcode;

  logic        w2_req;
  logic [31:0] w2_addr;
  logic        w2_valid;
  logic [31:0] w2_pc;
  logic [31:0] w2_instr;
  logic [6:0]  w2_opcode;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .opcode        (opcode)
  );

  // Second instance: free-running fetch from the top of the address space.
  instr_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (w2_req),
    .imem_addr     (w2_addr),
    .imem_rdata    (32'h0000_0033),
    .imem_ready    (1'b1),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .if_id_valid   (w2_valid),
    .if_id_pc      (w2_pc),
    .if_id_instr   (w2_instr),
    .opcode        (w2_opcode)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: what the IF stage should look like from the outside.
  bit          m_boot;
  bit          m_drop;
  logic [31:0] m_drop_addr;
  logic [31:0] m_pc;
  bit          m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic [63:0] m_skid[$];

  function automatic void model_reset();
    m_boot      = 1'b1;
    m_drop      = 1'b0;
    m_drop_addr = 32'h0;
    m_pc        = 32'h0;
    m_v         = 1'b0;
    m_ipc       = 32'h0;
    m_instr     = NOP;
    m_skid.delete();
  endfunction

  function automatic bit model_req();
    return !m_boot && (m_skid.size() == 0);
  endfunction

  function automatic logic [31:0] model_addr();
    return m_drop ? m_drop_addr : m_pc;
  endfunction

  function automatic void model_step(input bit rdy, input logic [31:0] rd, input bit st,
                                     input bit br, input logic [31:0] tgt);
    bit fetching;
    fetching = !m_boot && !m_drop && (m_skid.size() == 0);
    if (br) begin
      if (m_drop) begin
        if (rdy) m_drop = 1'b0;
      end else if (fetching && !rdy) begin
        m_drop      = 1'b1;
        m_drop_addr = m_pc;
      end
      m_boot = 1'b0;
      m_skid.delete();
      m_pc    = tgt & ~32'h3;
      m_v     = 1'b0;
      m_instr = NOP;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_drop) begin
      if (rdy) m_drop = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (!st) begin
        {m_ipc, m_instr} = m_skid.pop_front();
        m_v = 1'b1;
      end
    end else if (rdy) begin
      if (st && m_v) begin
        m_skid.push_back({m_pc, rd});
      end else begin
        m_ipc   = m_pc;
        m_instr = rd;
        m_v     = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_v = 1'b0;
    end
  endfunction

  task automatic compare_all(input string pfx);
    check_eq({pfx, ".req"}, 32'(imem_req), 32'(model_req()));
    if (model_req()) check_eq({pfx, ".addr"}, imem_addr, model_addr());
    check_eq({pfx, ".valid"}, 32'(if_id_valid), 32'(m_v));
    if (m_v) begin
      check_eq({pfx, ".pc"}, if_id_pc, m_ipc);
      check_eq({pfx, ".instr"}, if_id_instr, m_instr);
      check_eq({pfx, ".opcode"}, 32'(opcode), 32'(m_instr[6:0]));
    end
  endtask

  // Inputs are driven on the falling edge, outputs compared on the next falling edge.
  task automatic step(input string pfx, input bit rdy, input logic [31:0] rd, input bit st,
                      input bit br, input logic [31:0] tgt);
    imem_ready    = rdy;
    imem_rdata    = rd;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    model_step(rdy, rd, st, br, tgt);
    @(negedge clk);
    compare_all(pfx);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
  endfunction

  initial begin
    bit          rdy;
    bit          st;
    bit          br;
    logic [31:0] tgt;

    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst.req", 32'(imem_req), 32'h0);
    check_eq("rst.valid", 32'(if_id_valid), 32'h0);
    check_eq("rst.pc", if_id_pc, 32'h0);
    check_eq("rst.instr", if_id_instr, NOP);
    rst_n = 1'b1;

    // Boot idle cycle, then back-to-back fetch
    step("t1a", 1'b1, 32'h1234_5633, 1'b0, 1'b0, 32'h0);
    check_eq("t1.addr0", imem_addr, 32'h0);
    check_eq("t1.valid0", 32'(if_id_valid), 32'h0);
    step("t1b", 1'b1, 32'h1234_5633, 1'b0, 1'b0, 32'h0);
    check_eq("t1.valid1", 32'(if_id_valid), 32'h1);
    check_eq("t1.opcode", 32'(opcode), 32'h33);
    check_eq("t1.addr4", imem_addr, 32'h4);
    step("t1c", 1'b1, 32'h1234_5633, 1'b0, 1'b0, 32'h0);
    check_eq("t1.addr8", imem_addr, 32'h8);

    // Stall with a live IF/ID: word goes to skid, request drops
    step("t2a", 1'b1, 32'h1234_5603, 1'b1, 1'b0, 32'h0);
    check_eq("t2.req_hold", 32'(imem_req), 32'h0);
    check_eq("t2.pc_frozen", if_id_pc, 32'h4);
    step("t2b", 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    check_eq("t2.instr_frozen", if_id_instr, 32'h1234_5633);
    step("t2c", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    check_eq("t2.instr_skid", if_id_instr, 32'h1234_5603);
    check_eq("t2.pc_skid", if_id_pc, 32'h8);
    check_eq("t2.addr12", imem_addr, 32'hC);

    // Redirect beats stall and the ready data
    step("t3", 1'b1, 32'hAAAA_AAAA, 1'b1, 1'b1, 32'h0000_0102);
    check_eq("t3.valid", 32'(if_id_valid), 32'h0);
    check_eq("t3.opcode", 32'(opcode), 32'h13);
    check_eq("t3.addr", imem_addr, 32'h100);

    // Redirect while a request is outstanding: old address held, response dropped
    step("t4a", 1'b1, 32'hBBBB_BBBB, 1'b0, 1'b1, 32'h0000_0010);
    step("t4b", 1'b0, 32'hBBBB_BBBB, 1'b0, 1'b1, 32'h0000_0200);
    check_eq("t4.addr_held1", imem_addr, 32'h10);
    check_eq("t4.req_held", 32'(imem_req), 32'h1);
    step("t4c", 1'b0, 32'hBBBB_BBBB, 1'b0, 1'b0, 32'h0);
    check_eq("t4.addr_held2", imem_addr, 32'h10);
    step("t4d", 1'b1, 32'hDEAD_0033, 1'b0, 1'b0, 32'h0);
    check_eq("t4.dropped", 32'(if_id_valid), 32'h0);
    check_eq("t4.addr200", imem_addr, 32'h200);
    step("t4e", 1'b1, 32'h1234_5637, 1'b0, 1'b0, 32'h0);
    check_eq("t4.pc200", if_id_pc, 32'h200);

    // Asynchronous reset in the middle of a wait
    step("t6a", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6.req", 32'(imem_req), 32'h0);
    check_eq("t6.valid", 32'(if_id_valid), 32'h0);
    check_eq("t6.pc", if_id_pc, 32'h0);
    check_eq("t6.instr", if_id_instr, NOP);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("t6b", 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
    check_eq("t6.addr0", imem_addr, 32'h0);
    check_eq("t5.addr_top", w2_addr, WRAP_PC);
    step("t6c", 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
    check_eq("t5.addr_wrap", w2_addr, 32'h0);
    check_eq("t5.pc_top", w2_pc, WRAP_PC);
    check_eq("t5.valid", 32'(w2_valid), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        st  = ($urandom_range(0, 3) == 0);
        br  = ($urandom_range(0, 15) == 0);
        tgt = $urandom;
        step("rnd", rdy, mem_word(model_addr()), st, br, tgt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
